// File: rtl/alarm_buzzer_pkg.sv
// Shared state encoding, default timing constants and width helpers for the alarm buzzer.
// Also used by the clock/alarm stages so that the timing defaults agree.
package alarm_buzzer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRingOn  = 2'd1,
        StRingOff = 2'd2,
        StSnooze  = 2'd3
    } state_e;

    localparam int unsigned DEF_CLK_HZ      = 100_000_000;
    localparam int unsigned DEF_TONE_HZ     = 2000;
    localparam int unsigned DEF_BEEP_ON_MS  = 250;
    localparam int unsigned DEF_BEEP_OFF_MS = 250;
    localparam int unsigned DEF_SNOOZE_S    = 300;
    localparam int unsigned DEF_TIMEOUT_S   = 60;
    localparam int unsigned DEF_MAX_SNOOZE  = 3;
    localparam int unsigned SNOOZE_CNT_W    = 2;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_buzzer_if.sv
// Alarm buzzer control/status bundle: alarm level and buttons in, buzzer drive and LEDs out.
interface alarm_buzzer_if;
    import alarm_buzzer_pkg::*;

    logic                    alarm_sound;
    logic                    btn_snooze;
    logic                    btn_stop;
    logic                    buzzer;
    logic                    ringing;
    logic                    snoozing;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt;

    modport master (
        output alarm_sound, btn_snooze, btn_stop,
        input  buzzer, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  alarm_sound, btn_snooze, btn_stop,
        output buzzer, ringing, snoozing, snooze_cnt
    );

endinterface

// File: rtl/alarm_buzzer_tick_gen.sv
// Millisecond and second strobe generator; i_clear restarts both counts from zero so the
// first strobe after a clear lands exactly one period later.
module alarm_buzzer_tick_gen
    import alarm_buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_ms_tick,
    output logic o_s_tick
);

    localparam int unsigned MS_DIV = CLK_HZ / 1000;
    localparam int unsigned PRE_W  = cnt_width(MS_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [9:0]       r_ms;

    // Strobes depend only on registers: i_clear is derived from next state, which uses them.
    assign o_ms_tick = (r_pre == PRE_W'(MS_DIV - 1));
    assign o_s_tick  = o_ms_tick && (r_ms == 10'd999);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (i_clear) begin
            r_pre <= '0;
            r_ms  <= '0;
        end else if (o_ms_tick) begin
            r_pre <= '0;
            r_ms  <= o_s_tick ? 10'd0 : r_ms + 10'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/alarm_buzzer.sv
// Alarm buzzer: turns the alarm rising edge into a beeping piezo tone with snooze, stop
// and ring timeout. All status outputs are registered with the state.
module alarm_buzzer
    import alarm_buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned TONE_HZ     = DEF_TONE_HZ,
    parameter int unsigned BEEP_ON_MS  = DEF_BEEP_ON_MS,
    parameter int unsigned BEEP_OFF_MS = DEF_BEEP_OFF_MS,
    parameter int unsigned SNOOZE_S    = DEF_SNOOZE_S,
    parameter int unsigned TIMEOUT_S   = DEF_TIMEOUT_S,
    parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic           CLK100MHZ,
    input  logic           btn_reset_n,
    alarm_buzzer_if.slave  bus
);

    localparam int unsigned HALF   = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned HALF_W = cnt_width(HALF - 1);
    localparam int unsigned PH_W   = cnt_width(max3(BEEP_ON_MS, BEEP_OFF_MS, SNOOZE_S));
    localparam int unsigned TO_MS  = TIMEOUT_S * 1000;
    localparam int unsigned RING_W = cnt_width(TO_MS);

    state_e                  r_state, w_state_d;
    logic                    r_alarm_prev, r_prev_vld;
    logic                    r_tone, w_tone_d;
    logic [HALF_W-1:0]       r_half, w_half_d;
    logic [PH_W-1:0]         r_phase, w_phase_d;
    logic [RING_W-1:0]       r_ring_ms, w_ring_ms_d;
    logic [SNOOZE_CNT_W-1:0] r_snooze_cnt, w_snooze_cnt_d;
    logic                    r_ringing, r_snoozing;
    logic                    w_ms_tick, w_s_tick, w_rise, w_trans, w_in_ring;
    logic                    w_timeout, w_phase_done, w_ring_clr;

    alarm_buzzer_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .i_clk     (CLK100MHZ),
        .i_rst_n   (btn_reset_n),
        .i_clear   (w_trans),
        .o_ms_tick (w_ms_tick),
        .o_s_tick  (w_s_tick)
    );

    // r_prev_vld masks the first sampled cycle after reset so a held-high alarm does not restart.
    assign w_rise    = bus.alarm_sound && !r_alarm_prev && r_prev_vld;
    assign w_in_ring = (r_state == StRingOn) || (r_state == StRingOff);
    assign w_timeout = w_in_ring && w_ms_tick && (r_ring_ms == RING_W'(TO_MS - 1));
    assign w_trans   = (w_state_d != r_state);

    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            StRingOn:  w_phase_done = w_ms_tick && (r_phase == PH_W'(BEEP_ON_MS - 1));
            StRingOff: w_phase_done = w_ms_tick && (r_phase == PH_W'(BEEP_OFF_MS - 1));
            StSnooze:  w_phase_done = w_s_tick && (r_phase == PH_W'(SNOOZE_S - 1));
            default:   w_phase_done = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d      = r_state;
        w_snooze_cnt_d = r_snooze_cnt;
        w_ring_clr     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_d      = StRingOn;
                    w_snooze_cnt_d = '0;
                    w_ring_clr     = 1'b1;
                end
            end
            StRingOn, StRingOff: begin
                if (bus.btn_stop || w_timeout) begin
                    w_state_d = StIdle;
                end else if (bus.btn_snooze) begin
                    if (r_snooze_cnt < SNOOZE_CNT_W'(MAX_SNOOZE)) begin
                        w_state_d      = StSnooze;
                        w_snooze_cnt_d = r_snooze_cnt + SNOOZE_CNT_W'(1);
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_phase_done) begin
                    w_state_d = (r_state == StRingOn) ? StRingOff : StRingOn;
                end
            end
            StSnooze: begin
                if (bus.btn_stop) begin
                    w_state_d = StIdle;
                end else if (w_phase_done) begin
                    w_state_d  = StRingOn;
                    w_ring_clr = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_phase_d = r_phase;
        if (w_trans) begin
            w_phase_d = '0;
        end else if ((r_state == StSnooze) ? w_s_tick : (w_in_ring && w_ms_tick)) begin
            w_phase_d = r_phase + PH_W'(1);
        end

        w_ring_ms_d = r_ring_ms;
        if (w_ring_clr) begin
            w_ring_ms_d = '0;
        end else if (w_in_ring && w_ms_tick) begin
            w_ring_ms_d = r_ring_ms + RING_W'(1);
        end

        // Tone starts high on every RING_ON entry and is forced low everywhere else.
        w_tone_d = 1'b0;
        w_half_d = '0;
        if (w_state_d == StRingOn) begin
            if (r_state != StRingOn) begin
                w_tone_d = 1'b1;
            end else if (r_half == HALF_W'(HALF - 1)) begin
                w_tone_d = !r_tone;
            end else begin
                w_tone_d = r_tone;
                w_half_d = r_half + HALF_W'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge btn_reset_n) begin
        if (!btn_reset_n) begin
            r_state      <= StIdle;
            r_alarm_prev <= 1'b0;
            r_prev_vld   <= 1'b0;
            r_tone       <= 1'b0;
            r_half       <= '0;
            r_phase      <= '0;
            r_ring_ms    <= '0;
            r_snooze_cnt <= '0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_alarm_prev <= bus.alarm_sound;
            r_prev_vld   <= 1'b1;
            r_tone       <= w_tone_d;
            r_half       <= w_half_d;
            r_phase      <= w_phase_d;
            r_ring_ms    <= w_ring_ms_d;
            r_snooze_cnt <= w_snooze_cnt_d;
            r_ringing    <= (w_state_d == StRingOn) || (w_state_d == StRingOff);
            r_snoozing   <= (w_state_d == StSnooze);
        end
    end

    assign bus.buzzer     = r_tone;
    assign bus.ringing    = r_ringing;
    assign bus.snoozing   = r_snoozing;
    assign bus.snooze_cnt = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Scoreboard bench for alarm_buzzer: a timing-arithmetic reference model queues expected
// outputs per clock edge; a monitor pops and compares them after each edge.
module tb_alarm_buzzer;

    localparam int unsigned CLK_HZ      = 10_000;
    localparam int unsigned TONE_HZ     = 1000;
    localparam int unsigned BEEP_ON_MS  = 2;
    localparam int unsigned BEEP_OFF_MS = 2;
    localparam int unsigned SNOOZE_S    = 1;
    localparam int unsigned TIMEOUT_S   = 1;
    localparam int unsigned MAX_SNOOZE  = 2;

    localparam longint HALF        = CLK_HZ / (2 * TONE_HZ);
    localparam longint ON_CYC      = BEEP_ON_MS * (CLK_HZ / 1000);
    localparam longint OFF_CYC     = BEEP_OFF_MS * (CLK_HZ / 1000);
    localparam longint SNOOZE_CYC  = SNOOZE_S * CLK_HZ;
    localparam longint TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;

    localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_SNZ = 3;

    typedef struct packed {
        logic       buzzer;
        logic       ringing;
        logic       snoozing;
        logic [1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    alarm_buzzer_if bus ();

    alarm_buzzer #(
        .CLK_HZ      (CLK_HZ),
        .TONE_HZ     (TONE_HZ),
        .BEEP_ON_MS  (BEEP_ON_MS),
        .BEEP_OFF_MS (BEEP_OFF_MS),
        .SNOOZE_S    (SNOOZE_S),
        .TIMEOUT_S   (TIMEOUT_S),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .CLK100MHZ   (clk),
        .btn_reset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    obs_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    string  scen = "init";

    int     m_mode, m_cnt;
    longint m_cyc, m_t_entry, m_t_ring;
    bit     m_prev, m_known;

    function automatic obs_t get_obs();
        obs_t o;
        o.buzzer   = bus.buzzer;
        o.ringing  = bus.ringing;
        o.snoozing = bus.snoozing;
        o.cnt      = bus.snooze_cnt;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got buz=%b ring=%b snz=%b cnt=%0d required buz=%b ring=%b snz=%b cnt=%0d",
                     name, $time, got.buzzer, got.ringing, got.snoozing, got.cnt,
                     exp.buzzer, exp.ringing, exp.snoozing, exp.cnt);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_prev  = 1'b0;
        m_known = 1'b0;
    endtask

    task automatic model_goto(input int mode);
        m_mode    = mode;
        m_t_entry = m_cyc;
    endtask

    // Behaviour at one clock edge, timed from the cycle each state / ring period began.
    task automatic model_edge(input bit a, input bit sn, input bit st);
        bit     rise;
        longint in_state, in_ring;
        m_cyc++;
        rise     = a && m_known && !m_prev;
        m_prev   = a;
        m_known  = 1'b1;
        in_state = m_cyc - m_t_entry;
        in_ring  = m_cyc - m_t_ring;
        case (m_mode)
            M_IDLE: if (rise) begin
                model_goto(M_ON);
                m_t_ring = m_cyc;
                m_cnt    = 0;
            end
            M_ON, M_OFF: begin
                if (st || in_ring >= TIMEOUT_CYC) model_goto(M_IDLE);
                else if (sn) begin
                    if (m_cnt < MAX_SNOOZE) begin
                        m_cnt++;
                        model_goto(M_SNZ);
                    end else model_goto(M_IDLE);
                end
                else if (m_mode == M_ON && in_state >= ON_CYC) model_goto(M_OFF);
                else if (m_mode == M_OFF && in_state >= OFF_CYC) model_goto(M_ON);
            end
            default: begin
                if (st) model_goto(M_IDLE);
                else if (in_state >= SNOOZE_CYC) begin
                    model_goto(M_ON);
                    m_t_ring = m_cyc;
                end
            end
        endcase
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.buzzer   = (m_mode == M_ON) && ((((m_cyc - m_t_entry) / HALF) % 2) == 0);
        o.ringing  = (m_mode == M_ON) || (m_mode == M_OFF);
        o.snoozing = (m_mode == M_SNZ);
        o.cnt      = 2'(m_cnt);
        return o;
    endfunction

    task automatic step(input bit a, input bit sn, input bit st);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.alarm_sound = a;
        bus.btn_snooze  = sn;
        bus.btn_stop    = st;
        model_edge(a, sn, st);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n, input bit a);
        repeat (n) step(a, 1'b0, 1'b0);
    endtask

    // Reset is asserted between clock edges and must clear the outputs without waiting for one.
    task automatic do_reset(input bit a);
        @(negedge clk);
        bus.alarm_sound = a;
        bus.btn_snooze  = 1'b0;
        bus.btn_stop    = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset", get_obs(), '0);
        model_reset();
        exp_q.push_back('0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(scen, get_obs(), e);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog t=%0t got no end of stimulus required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit a;
        bus.alarm_sound = 1'b0;
        bus.btn_snooze  = 1'b0;
        bus.btn_stop    = 1'b0;
        model_reset();
        m_cyc = 0;
        #1 rst_n = 1'b0;
        #1 check("reset_state", get_obs(), '0);
        repeat (2) @(negedge clk);

        scen = "cadence_timeout";
        run(10, 1'b0);
        run(10_100, 1'b1);

        scen = "snooze";
        run(5, 1'b0);
        run(30, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run(10_060, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run(10_030, 1'b1);
        scen = "snooze_limit";
        step(1'b1, 1'b1, 1'b0);
        run(10, 1'b1);

        scen = "recount";
        run(3, 1'b0);
        run(7, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run(10_005, 1'b1);
        scen = "stop_and_snooze";
        step(1'b1, 1'b1, 1'b1);
        run(10, 1'b1);

        scen = "reset_mid_ring";
        run(3, 1'b0);
        run(13, 1'b1);
        do_reset(1'b1);
        run(50, 1'b1);
        run(2, 1'b0);
        run(10, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(3, 1'b1);

        scen = "stop_with_rise";
        run(2, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run(5, 1'b1);

        scen = "random";
        a = 1'b0;
        for (int i = 0; i < 30_000; i++) begin
            if (($urandom % 400) == 0) a = ~a;
            if (($urandom % 8000) == 0) do_reset(a);
            else step(a, ($urandom % 1500) == 0, ($urandom % 5000) == 0);
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
